pipeline_issue_ctrl: RTL and testbench

Issue controller between the decode stage (stage 0) and stage 1 of the pipeline. Each cycle it decides whether the decoded instruction may issue, or the front end must stall. It keeps a per-register scoreboard of pending writebacks and serialises memory operations (LDR/STR) to the single memory port. It also counts stall cycles for performance monitoring.

---
 rtl/pipeline_issue_ctrl.sv | 76 +++++++
 tb/tb_pipeline_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issue_ctrl.sv
// pipeline_issue_ctrl: decode-to-stage-1 issue gate with writeback scoreboard and memory-port serialisation
module pipeline_issue_ctrl #(
  parameter int WB_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [2:0]  num_Rm,
  input  logic [2:0]  num_Rn,
  input  logic [2:0]  num_Rd,
  input  logic [2:0]  used_RmRnRd,
  input  logic        write,
  input  logic [2:0]  writenum,
  input  logic [5:0]  inst_type,
  input  logic        mem_done,
  input  logic        flush,
  output logic        issue,
  output logic        stall,
  output logic [1:0]  stall_reason,
  output logic [7:0]  busy_mask,
  output logic        mem_busy,
  output logic [15:0] stall_cnt
);
  // Counting down from WB_LAT-1 releases the dependent exactly WB_LAT cycles after its producer
  localparam logic [2:0] LOAD_VAL = 3'(WB_LAT - 1);
  logic [7:0][2:0] cnt_q, cnt_d;
  logic [7:0]      ld_pend_q, ld_pend_d;
  logic            mem_busy_q, mem_busy_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic [7:0]      pend;
  logic            raw, waw, mem_hz, is_ld, is_mem;
  logic            unused_inst_bits;

  assign unused_inst_bits = ^inst_type[5:2];

  // Hazard evaluation, from registered state only (no same-cycle bypass)
  always_comb begin
    for (int r = 0; r < 8; r++) pend[r] = (cnt_q[r] != 3'd0) | ld_pend_q[r];
    is_ld        = inst_type[0];
    is_mem       = inst_type[0] | inst_type[1];
    raw          = (used_RmRnRd[2] & pend[num_Rm]) | (used_RmRnRd[1] & pend[num_Rn]) | (used_RmRnRd[0] & pend[num_Rd]);
    waw          = write & pend[writenum];
    mem_hz       = is_mem & mem_busy_q;
    issue        = dec_valid & ~flush & ~raw & ~waw & ~mem_hz;
    stall        = dec_valid & ~issue;
    stall_reason = (~dec_valid | flush) ? 2'b00 : raw ? 2'b01 : waw ? 2'b10 : mem_hz ? 2'b11 : 2'b00;
  end

  // Next state: ALU countdowns, load-pending bits, memory port and saturating stall counter
  always_comb begin
    for (int r = 0; r < 8; r++)
      cnt_d[r] = flush ? 3'd0 : (issue & write & ~is_ld & (writenum == 3'(r))) ? LOAD_VAL : cnt_q[r] - 3'(cnt_q[r] != 3'd0);
    ld_pend_d   = ((flush | (mem_done & mem_busy_q)) ? 8'h00 : ld_pend_q) | ({7'd0, issue & is_ld} << writenum);
    mem_busy_d  = flush ? 1'b0 : (issue & is_mem) ? 1'b1 : mem_done ? 1'b0 : mem_busy_q;
    stall_cnt_d = stall_cnt_q + 16'(stall & ~flush & (stall_cnt_q != 16'hFFFF));
  end

  // State registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      ld_pend_q   <= '0;
      mem_busy_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ld_pend_q   <= ld_pend_d;
      mem_busy_q  <= mem_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_mask = pend;
  assign mem_busy  = mem_busy_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// tb_pipeline_issue_ctrl: directed and randomized checks of the issue controller against a readiness-time model
module tb_pipeline_issue_ctrl;
  localparam int WB = 3;
  logic        clk = 0, reset = 0, dec_valid = 0, write = 0, mem_done = 0, flush = 0;
  logic [2:0]  num_Rm = 0, num_Rn = 0, num_Rd = 0, used_RmRnRd = 0, writenum = 0;
  logic [5:0]  inst_type = 0;
  logic        issue, stall, mem_busy;
  logic [1:0]  stall_reason;
  logic [7:0]  busy_mask;
  logic [15:0] stall_cnt;
  int errs = 0, checks = 0;
  int cyc = 0;
  int ready[8];
  bit ldp[8];
  bit mb;
  int sc;
  int base;

  pipeline_issue_ctrl #(.WB_LAT(WB)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .num_Rm(num_Rm), .num_Rn(num_Rn), .num_Rd(num_Rd),
    .used_RmRnRd(used_RmRnRd), .write(write), .writenum(writenum), .inst_type(inst_type),
    .mem_done(mem_done), .flush(flush), .issue(issue), .stall(stall), .stall_reason(stall_reason),
    .busy_mask(busy_mask), .mem_busy(mem_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a register is busy until the absolute cycle its value becomes readable, or while its load is outstanding
  function automatic bit pend(int r);
    return (cyc < ready[r]) || ldp[r];
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m;
    for (int r = 0; r < 8; r++) m[r] = pend(r);
    return m;
  endfunction

  function automatic logic [1:0] m_reason();
    bit raw, waw, mh;
    raw = (used_RmRnRd[2] && pend(int'(num_Rm))) || (used_RmRnRd[1] && pend(int'(num_Rn))) || (used_RmRnRd[0] && pend(int'(num_Rd)));
    waw = write && pend(int'(writenum));
    mh  = (inst_type[0] || inst_type[1]) && mb;
    if (!dec_valid || flush) return 2'b00;
    return raw ? 2'b01 : waw ? 2'b10 : mh ? 2'b11 : 2'b00;
  endfunction

  function automatic bit m_issue();
    return dec_valid && !flush && (m_reason() == 2'b00);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mb <= 0;
      sc <= 0;
      for (int r = 0; r < 8; r++) begin
        ready[r] <= 0;
        ldp[r]   <= 0;
      end
    end else begin
      if (flush) begin
        mb <= 0;
        for (int r = 0; r < 8; r++) begin
          ready[r] <= 0;
          ldp[r]   <= 0;
        end
      end else begin
        if (mem_done && mb) begin
          mb <= 0;
          for (int r = 0; r < 8; r++) ldp[r] <= 0;
        end
        if (m_issue() && inst_type[0]) begin
          ldp[writenum] <= 1;
          mb <= 1;
        end
        if (m_issue() && inst_type[1]) mb <= 1;
        if (m_issue() && write && !inst_type[0]) ready[writenum] <= cyc + WB;
      end
      if (dec_valid && !flush && !m_issue() && sc < 65535) sc <= sc + 1;
    end
  end

  task automatic set_in(input logic v, input logic [2:0] rm, input logic [2:0] rn, input logic [2:0] rd,
                        input logic [2:0] used, input logic w, input logic [2:0] wn, input logic [5:0] it);
    dec_valid = v; num_Rm = rm; num_Rn = rn; num_Rd = rd;
    used_RmRnRd = used; write = w; writenum = wn; inst_type = it;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    mem_done = 0; flush = 0;
    reset = 1;
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1;
    tick();
    checks++; if ({busy_mask, mem_busy, stall_cnt} !== 25'd0) begin errs++; $display("FAIL reset_state: got busy=%h mem=%b cnt=%0d want 0", busy_mask, mem_busy, stall_cnt); end
    checks++; if ({issue, stall} !== 2'b00) begin errs++; $display("FAIL reset_bubble: got issue=%b stall=%b want 0 0", issue, stall); end
    reset = 0;
    tick();
    set_in(1, 0, 0, 0, 3'b010, 1, 3, 6'b000001);
    tick();
    set_in(1, 2, 0, 0, 3'b100, 1, 1, 6'b000000);
    tick();
    set_in(1, 1, 0, 0, 3'b100, 0, 0, 6'b000000);
    tick();
    checks++; if ({busy_mask, mem_busy, stall_cnt} !== {8'h0A, 1'b1, 16'd1}) begin errs++; $display("FAIL reset_loaded: got busy=%h mem=%b cnt=%0d want 0a 1 1", busy_mask, mem_busy, stall_cnt); end
    #2 reset = 1;
    #1;
    checks++; if ({busy_mask, mem_busy, stall_cnt} !== 25'd0) begin errs++; $display("FAIL reset_async: got busy=%h mem=%b cnt=%0d want 0", busy_mask, mem_busy, stall_cnt); end
    tick();
    reset = 0;
    #1;
    checks++; if (issue !== 1'b1) begin errs++; $display("FAIL reset_first_issue: got %b want 1", issue); end
  endtask

  task automatic test_alu_raw();
    do_reset();
    set_in(1, 2, 3, 0, 3'b110, 1, 1, 6'b000000);
    #1;
    checks++; if (issue !== 1'b1) begin errs++; $display("FAIL alu_producer: got issue=%b want 1", issue); end
    base = int'(stall_cnt);
    tick();
    set_in(1, 1, 3, 0, 3'b110, 1, 2, 6'b000000);
    for (int k = 1; k <= WB - 1; k++) begin
      #1;
      checks++; if ({issue, stall, stall_reason} !== 4'b0101) begin errs++; $display("FAIL alu_raw_stall t+%0d: got issue=%b stall=%b reason=%b want 0 1 01", k, issue, stall, stall_reason); end
      tick();
    end
    #1;
    checks++; if ({issue, stall, stall_reason} !== 4'b1000) begin errs++; $display("FAIL alu_raw_issue: got issue=%b stall=%b reason=%b want 1 0 00", issue, stall, stall_reason); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (stall_cnt !== 16'(base + WB - 1)) begin errs++; $display("FAIL alu_raw_count: got %0d want %0d", stall_cnt, base + WB - 1); end
    checks++; if (busy_mask !== 8'h04) begin errs++; $display("FAIL alu_raw_mask: got %h want 04", busy_mask); end
  endtask

  task automatic test_ldr_use();
    do_reset();
    set_in(1, 0, 0, 0, 3'b010, 1, 4, 6'b000001);
    #1;
    checks++; if (issue !== 1'b1) begin errs++; $display("FAIL ldr_issue: got %b want 1", issue); end
    tick();
    set_in(1, 4, 0, 0, 3'b100, 1, 5, 6'b000000);
    for (int k = 1; k <= 5; k++) begin
      mem_done = (k == 5);
      #1;
      checks++; if ({issue, stall_reason, busy_mask, mem_busy} !== {1'b0, 2'b01, 8'h10, 1'b1}) begin errs++; $display("FAIL ldr_wait t+%0d: got issue=%b reason=%b busy=%h mem=%b want 0 01 10 1", k, issue, stall_reason, busy_mask, mem_busy); end
      tick();
    end
    mem_done = 0;
    #1;
    checks++; if ({issue, busy_mask, mem_busy} !== {1'b1, 8'h00, 1'b0}) begin errs++; $display("FAIL ldr_use_issue: got issue=%b busy=%h mem=%b want 1 00 0", issue, busy_mask, mem_busy); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (busy_mask !== 8'h20) begin errs++; $display("FAIL ldr_use_mask: got %h want 20", busy_mask); end
  endtask

  task automatic test_mem_waw();
    do_reset();
    set_in(1, 0, 0, 6, 3'b011, 0, 0, 6'b000010);
    #1;
    checks++; if (issue !== 1'b1) begin errs++; $display("FAIL str1_issue: got %b want 1", issue); end
    tick();
    set_in(1, 0, 0, 7, 3'b011, 0, 0, 6'b111110);
    for (int k = 1; k <= 4; k++) begin
      mem_done = (k == 4);
      #1;
      checks++; if ({issue, stall_reason} !== 3'b011) begin errs++; $display("FAIL str2_stall t+%0d: got issue=%b reason=%b want 0 11", k, issue, stall_reason); end
      tick();
    end
    mem_done = 0;
    #1;
    checks++; if (issue !== 1'b1) begin errs++; $display("FAIL str2_issue: got %b want 1", issue); end
    tick();
    set_in(1, 3, 0, 0, 3'b100, 1, 2, 6'b000000);
    #1;
    checks++; if (issue !== 1'b1) begin errs++; $display("FAIL mov1_issue: got %b want 1", issue); end
    tick();
    for (int k = 1; k <= WB - 1; k++) begin
      #1;
      checks++; if ({issue, stall_reason} !== 3'b010) begin errs++; $display("FAIL waw_stall t+%0d: got issue=%b reason=%b want 0 10", k, issue, stall_reason); end
      tick();
    end
    #1;
    checks++; if (issue !== 1'b1) begin errs++; $display("FAIL waw_issue: got %b want 1", issue); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 0, 0, 6, 3'b011, 0, 0, 6'b000010);
    tick();
    set_in(1, 3, 0, 0, 3'b100, 1, 1, 6'b000000);
    tick();
    set_in(1, 3, 0, 0, 3'b100, 1, 2, 6'b000000);
    tick();
    checks++; if ({busy_mask, mem_busy} !== {8'h06, 1'b1}) begin errs++; $display("FAIL flush_pre: got busy=%h mem=%b want 06 1", busy_mask, mem_busy); end
    base = int'(stall_cnt);
    set_in(1, 1, 2, 0, 3'b110, 1, 3, 6'b000000);
    flush = 1;
    #1;
    checks++; if (issue !== 1'b0) begin errs++; $display("FAIL flush_issue: got %b want 0", issue); end
    tick();
    flush = 0;
    #1;
    checks++; if ({busy_mask, mem_busy, issue, stall} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin errs++; $display("FAIL flush_after: got busy=%h mem=%b issue=%b stall=%b want 00 0 1 0", busy_mask, mem_busy, issue, stall); end
    checks++; if (stall_cnt !== 16'(base)) begin errs++; $display("FAIL flush_count: got %0d want %0d", stall_cnt, base); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int k;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 5);
      set_in($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             k == 0 ? 1'b1 : k == 1 ? 1'b0 : ($urandom_range(0, 3) != 0), 3'($urandom),
             {4'($urandom), k == 1, k == 0});
      mem_done = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 29) == 0);
      #1;
      checks++; if ({issue, stall, stall_reason} !== {m_issue(), dec_valid && !m_issue(), m_reason()}) begin errs++; $display("FAIL rand_comb %0d: got issue=%b stall=%b reason=%b want %b %b %b", n, issue, stall, stall_reason, m_issue(), dec_valid && !m_issue(), m_reason()); end
      tick();
      checks++; if ({busy_mask, mem_busy, stall_cnt} !== {m_mask(), mb, 16'(sc)}) begin errs++; $display("FAIL rand_state %0d: got busy=%h mem=%b cnt=%0d want %h %b %0d", n, busy_mask, mem_busy, stall_cnt, m_mask(), mb, sc); end
    end
    mem_done = 0; flush = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(1, 0, 0, 0, 3'b010, 1, 4, 6'b000001);
    tick();
    set_in(1, 4, 0, 0, 3'b100, 0, 0, 6'b000000);
    repeat (70000) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_count: got %h want ffff", stall_cnt); end
    checks++; if ({stall, 16'(sc)} !== {1'b1, 16'hFFFF}) begin errs++; $display("FAIL sat_stall: got stall=%b model=%h want 1 ffff", stall, sc); end
  endtask

  initial begin
    test_reset();
    test_alu_raw();
    test_ldr_use();
    test_mem_waw();
    test_flush();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
